intirvx_writeback_arbiter: RTL
==============================

# intirvx_writeback_arbiter

Collects results from the intirvx calculation units (ALU, LSU, CSR/multiplier, …) and serialises them onto the single register-file write port `wb`/`wb_valid` consumed by `intirvx_register_manager`. It is the producer end of the writeback interface. Each source has a one-entry result buffer. A round-robin arbiter retires at most one result per cycle, so no unit stalls another indefinitely.

## Interface
- `N_SRC`, default 3: number of calculation-unit sources. Legal range is 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `src_valid`  in  N_SRC  per-source result valid.
- `src_ready`  out  N_SRC  per-source result accepted when high with `src_valid`.
- `src_wb`  in  N_SRC x wb_bus  per-source result (`adr` [4:0], `data` [xlen-1:0]).
- `src_instret`  in  N_SRC  result retires an instruction (counted only under the configuration macro).
- `wb`  out  wb_bus  register-file write address and data.
- `wb_valid`  out  1  register-file write strobe. No ready: the register file always accepts.
- `wb_retired`  out  64  retired-instruction count. Present only with `INTIRVX_WB_RETIRE_CNT_EN`.

## Operation
- **Per-source state:**
  - `buf_full[i]` (reset 0)
  - `buf_wb[i]`
  - `buf_instret[i]`
- **Arbitration:**
  - Among sources with `buf_full` set, grant the first one found scanning upward from `rr_ptr`, wrapping modulo N_SRC.
  - `rr_ptr` resets to 0.
- **Output:**
  - `wb_valid` = OR of `buf_full`.
  - `wb` = `buf_wb[grant]`.
  - When no buffer is full, `wb` is 0.
- **Retire:** on a cycle with a grant, clear `buf_full[grant]` and set `rr_ptr` = (grant+1) mod N_SRC. With no grant, `rr_ptr` holds.
- **Ready:**
  - `src_ready[i]` = !`buf_full[i]` | `grant[i]`.
  - It depends on registered state only; there is no combinational path from `src_valid` to `src_ready`.
- **Accept:**
  - When `src_valid[i]` and `src_ready[i]` are both high, load the buffer and set `buf_full[i]`.
  - Accept and retire on the same source in the same cycle leaves `buf_full[i]` = 1 with the new data.
- **x0:** results with `adr` = 0 are retired normally. The register file discards them.
- **No flush port:** any result presented by a unit is architecturally committed and always written.
- **Source behaviour:** `src_valid` may drop without a handshake. The arbiter never samples a result unless the handshake completes.

## Timing
- **Latency:** a source handshake in cycle N makes `wb_valid` high with that result in cycle N+1 at the earliest.
- **Throughput:**
  - One write per cycle total.
  - A lone source sustains one result per cycle.
  - With k sources continuously busy, each retires once every k cycles.
- **Fairness:** a full buffer is granted within N_SRC cycles.
- **Reset:** asserting `rst_n` low mid-operation immediately drops all buffered results and drives:
  - `wb_valid` = 0, `wb` = 0
  - `src_ready` = all ones
  - `rr_ptr` = 0
  - `wb_retired` = 0
- **Simultaneous arrival:** when all sources hand over in the same cycle, they retire in order `rr_ptr`, `rr_ptr`+1, … on consecutive cycles.

## Configuration
- `INTIRVX_WB_RETIRE_CNT_EN`:
  - **Defined:** a 64-bit counter `wb_retired` increments by 1 on each grant whose `buf_instret` is set. It wraps from all-ones to 0 and resets to 0.
  - **Undefined:** the port and counter are absent, and `src_instret` is ignored.

## Structure
- `wb_bus` lives in `interfaces_pkg` and is already shared with the register manager.
- `xlen` comes from `cpu_parameters`.
- Add `WB_MAX_SRC` = 8 to `cpu_parameters`.
- One sub-module: `intirvx_rr_arbiter`.
  - Parameter N.
  - Inputs: request vector and pointer.
  - Output: one-hot grant.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
1. **Reset and single result.**
   - Stimulus: reset, then source 0 presents adr 5, data 0xDEADBEEF.
   - Required: `wb_valid` = 0 during reset; `wb_valid` = 1 with adr 5, data 0xDEADBEEF exactly one cycle after the handshake; then 0.
2. **Simultaneous arrival.**
   - Stimulus: sources 0, 1 and 2 present adr 1, 2 and 3 in the same cycle, with `rr_ptr` = 0.
   - Required: writes to 1, 2, 3 on three consecutive cycles; `src_ready[2]` stays low until its grant.
3. **Back-to-back lone source.**
   - Stimulus: source 1 presents 10 results over 10 cycles.
   - Required: `src_ready[1]` never drops; 10 consecutive `wb_valid` cycles in order.
4. **Fairness under load.**
   - Stimulus: all three sources held valid for 30 cycles.
   - Required: exactly 10 grants per source; no source waits more than 3 cycles.
5. **Reset mid-operation.**
   - Stimulus: assert `rst_n` low with 2 buffers full.
   - Required: `wb_valid` drops in the same cycle; after release, no stale write appears.
6. **Retire counter.**
   - Stimulus: with `INTIRVX_WB_RETIRE_CNT_EN`, send 7 results of which 4 have `src_instret` set.
   - Required: `wb_retired` = 4 after the last write.

Source files
------------

// File: rtl/cpu_parameters.sv
// Core-wide sizing constants shared by the intirvx pipeline blocks.
package cpu_parameters;
  localparam int xlen       = 32;
  localparam int WB_MAX_SRC = 8;
endpackage

// File: rtl/interfaces_pkg.sv
// Bus types shared between intirvx units; wb_bus is the register-file write port.
package interfaces_pkg;
  import cpu_parameters::*;

  typedef struct packed {
    logic [4:0]      adr;
    logic [xlen-1:0] data;
  } wb_bus;
endpackage

// File: rtl/intirvx_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module intirvx_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/intirvx_writeback_arbiter.sv
// Serialises per-unit results onto the single register-file write port.
// Optional retired-instruction counter: define INTIRVX_WB_RETIRE_CNT_EN.
module intirvx_writeback_arbiter
  import interfaces_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src_valid,
  output logic [N_SRC-1:0]  src_ready,
  input  wb_bus [N_SRC-1:0] src_wb,
  input  logic [N_SRC-1:0]  src_instret,
  output wb_bus             wb,
  output logic              wb_valid
`ifdef INTIRVX_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       wb_retired
`endif
);
  localparam int PW = $clog2(N_SRC);

  logic [N_SRC-1:0]  buf_full_q, buf_full_d;
  wb_bus [N_SRC-1:0] buf_wb_q, buf_wb_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0]  gnt, acc;
  logic [PW-1:0]     gnt_idx;

  intirvx_rr_arbiter #(.N(N_SRC)) u_rr (
    .req (buf_full_q),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // A buffer being drained this cycle can take a new result in the same cycle.
  assign src_ready = ~buf_full_q | gnt;
  assign acc       = src_valid & src_ready;
  assign wb_valid  = |buf_full_q;

  always_comb begin
    wb      = '0;
    gnt_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        wb      = buf_wb_q[i];
        gnt_idx = PW'(i);
      end
    end
  end

  always_comb begin
    buf_full_d = (buf_full_q & ~gnt) | acc;
    buf_wb_d   = buf_wb_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (acc[i]) buf_wb_d[i] = src_wb[i];
    end
    rr_ptr_d = rr_ptr_q;
    if (wb_valid) rr_ptr_d = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= '0;
      buf_wb_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_wb_q   <= buf_wb_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef INTIRVX_WB_RETIRE_CNT_EN
  logic [N_SRC-1:0] buf_instret_q, buf_instret_d;
  logic [63:0]      wb_retired_q, wb_retired_d;

  always_comb begin
    buf_instret_d = (buf_instret_q & ~acc) | (src_instret & acc);
    wb_retired_d  = wb_retired_q + 64'(|(gnt & buf_instret_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instret_q <= '0;
      wb_retired_q  <= '0;
    end else begin
      buf_instret_q <= buf_instret_d;
      wb_retired_q  <= wb_retired_d;
    end
  end

  assign wb_retired = wb_retired_q;
`else
  logic unused_instret;
  assign unused_instret = ^src_instret;
`endif
endmodule
